// File: rtl/width_unpack_pkg.sv
// Shared constants for the sample-width unpacker: mode codes, FSM state
// encodings and default widths.
package width_unpack_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int CNT_IN_W_DEF = 5;

  // width_sel codes; reserved codes 2 and 3 behave as 16-bit
  localparam logic [1:0] WSEL_8B  = 2'd0;
  localparam logic [1:0] WSEL_16B = 2'd1;

  // FSM state encodings
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_LO_PEND = 1'b1;

  // True only for the packed two-samples-per-word mode
  function automatic logic is_8b_mode(input logic [1:0] wsel);
    return (wsel == WSEL_8B);
  endfunction

endpackage

// File: rtl/width_unpack_expand.sv
// Places a half-width sample into a full-width output word: either in the
// upper half with the lower half zero-filled, or sign-extended in the lower
// half.
module width_unpack_expand #(
  parameter int DATA_W   = 16,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic [DATA_W/2-1:0] half_in,
  output logic [DATA_W-1:0]   sample_out
);

  localparam int HALF_W = DATA_W / 2;

  generate
    if (SIGN_EXT) begin : g_sext
      assign sample_out = {{HALF_W{half_in[HALF_W-1]}}, half_in};
    end else begin : g_upper
      assign sample_out = {half_in, {HALF_W{1'b0}}};
    end
  endgenerate

endmodule

// File: rtl/width_unpack.sv
// Unpacks 16-bit words from the DDC packer back into one sample per cycle.
// In 8-bit mode a word yields two samples on consecutive cycles (upper byte
// first); in 16-bit mode the word passes straight through. Sample index and
// sync enable are regenerated at the sample rate.
module width_unpack
  import width_unpack_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_IN_W = CNT_IN_W_DEF,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_sync_in,
  input  logic [CNT_IN_W-1:0] cnt_sync_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [1:0]          width_sel,
  output logic                in_ready,
  output logic                en_sync_out,
  output logic [CNT_IN_W:0]   cnt_sync_out,
  output logic [DATA_W-1:0]   data_out,
  output logic                overflow
);

  localparam int HALF_W = DATA_W / 2;

  logic [0:0]          state_r;
  logic [1:0]          mode_r;      // width_sel latched on the last accepted word
  logic [HALF_W-1:0]   lo_hold_r;   // second sample of an 8-bit word
  logic [CNT_IN_W-1:0] cnt_hold_r;  // word index belonging to lo_hold_r

  logic                accept_s;
  logic                sel_8b_s;
  logic [DATA_W-1:0]   hi_exp_s;
  logic [DATA_W-1:0]   lo_exp_s;

  // A word can only be taken when no lo byte is waiting to go out
  assign in_ready = (state_r == S_IDLE);
  assign accept_s = en_sync_in & in_ready;
  assign sel_8b_s = is_8b_mode(width_sel);

  width_unpack_expand #(
    .DATA_W   (DATA_W),
    .SIGN_EXT (SIGN_EXT)
  ) u_expand_hi (
    .half_in    (data_in[DATA_W-1:HALF_W]),
    .sample_out (hi_exp_s)
  );

  width_unpack_expand #(
    .DATA_W   (DATA_W),
    .SIGN_EXT (SIGN_EXT)
  ) u_expand_lo (
    .half_in    (lo_hold_r),
    .sample_out (lo_exp_s)
  );

  // Unpack FSM: accept words in S_IDLE, emit the held lo byte in S_LO_PEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      mode_r       <= WSEL_16B;
      lo_hold_r    <= {HALF_W{1'b0}};
      cnt_hold_r   <= {CNT_IN_W{1'b0}};
      en_sync_out  <= 1'b0;
      cnt_sync_out <= {(CNT_IN_W+1){1'b0}};
      data_out     <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            mode_r      <= width_sel;
            en_sync_out <= 1'b1;
            if (sel_8b_s) begin
              data_out     <= hi_exp_s;
              cnt_sync_out <= {cnt_sync_in, 1'b0};
              lo_hold_r    <= data_in[HALF_W-1:0];
              cnt_hold_r   <= cnt_sync_in;
              state_r      <= S_LO_PEND;
            end else begin
              data_out     <= data_in;
              cnt_sync_out <= {1'b0, cnt_sync_in};
              state_r      <= S_IDLE;
            end
          end else begin
            en_sync_out <= 1'b0;
          end
        end
        S_LO_PEND: begin
          // S_LO_PEND is only entered from an 8-bit word; anything else is a
          // corrupted state and is retired without a pulse
          if (is_8b_mode(mode_r)) begin
            data_out     <= lo_exp_s;
            cnt_sync_out <= {cnt_hold_r, 1'b1};
            en_sync_out  <= 1'b1;
          end else begin
            en_sync_out  <= 1'b0;
          end
          state_r <= S_IDLE;
        end
        default: begin
          en_sync_out <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky flag for a word offered while the lo byte was still pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (en_sync_in && !in_ready) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_width_unpack.sv
// Scoreboard bench for width_unpack. Two instances share the stimulus: one
// with upper-half placement, one with sign extension. Expected samples are
// queued as stimulus is issued; a negedge monitor pops and compares.
module tb_width_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_sync_in;
  logic [4:0]  cnt_sync_in;
  logic [15:0] data_in;
  logic [1:0]  width_sel;

  logic        in_ready0, en0, ovf0;
  logic [5:0]  cnt0;
  logic [15:0] d0;
  logic        in_ready1, en1, ovf1;
  logic [5:0]  cnt1;
  logic [15:0] d1;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [5:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  int run_len = 0;
  int last_run = 0;

  always #5 clk = ~clk;

  width_unpack #(.DATA_W(16), .CNT_IN_W(5), .SIGN_EXT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .en_sync_in(en_sync_in), .cnt_sync_in(cnt_sync_in),
    .data_in(data_in), .width_sel(width_sel), .in_ready(in_ready0),
    .en_sync_out(en0), .cnt_sync_out(cnt0), .data_out(d0), .overflow(ovf0)
  );

  width_unpack #(.DATA_W(16), .CNT_IN_W(5), .SIGN_EXT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .en_sync_in(en_sync_in), .cnt_sync_in(cnt_sync_in),
    .data_in(data_in), .width_sel(width_sel), .in_ready(in_ready1),
    .en_sync_out(en1), .cnt_sync_out(cnt1), .data_out(d1), .overflow(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] e0, input logic [15:0] e1, input logic [5:0] c);
    exp_t e;
    e.d0  = e0;
    e.d1  = e1;
    e.cnt = c;
    sb.push_back(e);
  endtask

  // drive one cycle of input, then step to 1 time unit past the next edge
  task automatic cyc(input logic e, input logic [1:0] w, input logic [4:0] c, input logic [15:0] d);
    en_sync_in  = e;
    width_sel   = w;
    cnt_sync_in = c;
    data_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd1, 5'd0, 16'h0000);
  endtask

  // monitor: pop and compare on every output pulse, track pulse run length
  always @(negedge clk) begin
    if (en0 || en1) begin
      run_len++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: pulse with empty scoreboard, data0=%h data1=%h cnt=%0d", d0, d1, cnt0);
      end else begin
        mon_e = sb.pop_front();
        chk("en_sync_out0", {31'd0, en0}, 32'd1);
        chk("en_sync_out1", {31'd0, en1}, 32'd1);
        chk("data_out0", {16'd0, d0}, {16'd0, mon_e.d0});
        chk("data_out1", {16'd0, d1}, {16'd0, mon_e.d1});
        chk("cnt_sync_out0", {26'd0, cnt0}, {26'd0, mon_e.cnt});
        chk("cnt_sync_out1", {26'd0, cnt1}, {26'd0, mon_e.cnt});
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  initial begin
    rst = 1'b1;
    en_sync_in = 1'b0;
    width_sel = 2'd1;
    cnt_sync_in = 5'd0;
    data_in = 16'h0000;
    idle(2);
    chk("rst_en", {31'd0, en0}, 32'd0);
    chk("rst_data", {16'd0, d0}, 32'd0);
    chk("rst_cnt", {26'd0, cnt0}, 32'd0);
    chk("rst_ovf", {31'd0, ovf0}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    rst = 1'b0;
    idle(2);

    // 16-bit pass-through, one word per cycle
    push(16'h1234, 16'h1234, 6'd0); cyc(1'b1, 2'd1, 5'd0, 16'h1234);
    push(16'h5678, 16'h5678, 6'd1); cyc(1'b1, 2'd1, 5'd1, 16'h5678);
    push(16'h9ABC, 16'h9ABC, 6'd2); cyc(1'b1, 2'd1, 5'd2, 16'h9ABC);
    push(16'hDEF0, 16'hDEF0, 6'd3); cyc(1'b1, 2'd1, 5'd3, 16'hDEF0);
    idle(3);
    chk("run_16b", last_run, 32'd4);
    chk("ovf_16b", {31'd0, ovf0}, 32'd0);

    // 8-bit words every 2 cycles give a continuous sample stream
    push(16'hA100, 16'hFFA1, 6'd0);
    push(16'hB200, 16'hFFB2, 6'd1);
    cyc(1'b1, 2'd0, 5'd0, 16'hA1B2);
    chk("in_ready_lo_pend", {31'd0, in_ready0}, 32'd0);
    cyc(1'b0, 2'd0, 5'd0, 16'h0000);
    push(16'hC300, 16'hFFC3, 6'd2);
    push(16'hD400, 16'hFFD4, 6'd3);
    cyc(1'b1, 2'd0, 5'd1, 16'hC3D4);
    idle(3);
    chk("run_8b", last_run, 32'd4);
    chk("ovf_8b", {31'd0, ovf0}, 32'd0);

    // sign extension and index wrap at cnt 31
    push(16'h8000, 16'hFF80, 6'd62);
    push(16'h7F00, 16'h007F, 6'd63);
    cyc(1'b1, 2'd0, 5'd31, 16'h807F);
    idle(3);
    chk("run_wrap", last_run, 32'd2);

    // back-to-back 8-bit words: second dropped, overflow sticky
    push(16'h1100, 16'h0011, 6'd4);
    push(16'h2200, 16'h0022, 6'd5);
    cyc(1'b1, 2'd0, 5'd2, 16'h1122);
    cyc(1'b1, 2'd0, 5'd3, 16'h3344);
    chk("ovf_set0", {31'd0, ovf0}, 32'd1);
    chk("ovf_set1", {31'd0, ovf1}, 32'd1);
    idle(3);
    chk("run_drop", last_run, 32'd2);
    chk("ovf_sticky", {31'd0, ovf0}, 32'd1);

    // mode change during S_LO_PEND affects only the next word
    push(16'h5500, 16'h0055, 6'd14);
    push(16'h6600, 16'h0066, 6'd15);
    push(16'hABCD, 16'hABCD, 6'd8);
    cyc(1'b1, 2'd0, 5'd7, 16'h5566);
    cyc(1'b0, 2'd1, 5'd0, 16'h0000);
    cyc(1'b1, 2'd1, 5'd8, 16'hABCD);
    idle(3);
    chk("run_switch", last_run, 32'd3);

    // asynchronous reset while the lo byte is pending
    push(16'h7700, 16'h0077, 6'd18);
    cyc(1'b1, 2'd0, 5'd9, 16'h7788);
    chk("in_ready_pend2", {31'd0, in_ready0}, 32'd0);
    en_sync_in = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_en0", {31'd0, en0}, 32'd0);
    chk("arst_en1", {31'd0, en1}, 32'd0);
    chk("arst_data0", {16'd0, d0}, 32'd0);
    chk("arst_data1", {16'd0, d1}, 32'd0);
    chk("arst_cnt", {26'd0, cnt0}, 32'd0);
    chk("arst_ovf", {31'd0, ovf0}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready0}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    chk("post_rst_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("post_rst_en", {31'd0, en0}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
